multi_cycle_control_fsm: RTL and testbench
==========================================

Name: multi_cycle_control_fsm

Overview:
- Control unit for the multi-cycle MIPS datapath.
- Replaces single-cycle combinational decode with a Moore FSM: IF, ID, EX, MEM, WB.
- Adds parametrised memory wait handshake, ALU-op width and a retired-instruction counter.
- Sits between the instruction register (opcode/funct) and all datapath mux selects and write strobes.

Parameters:
- ALU_OP_W, 4, width of alu_op; encoding in low 4 bits, upper bits zero.
- MEM_HS, 1, 1 = IF/MEM wait for mem_ready; 0 = mem_ready ignored (treated as 1).
- CNT_W, 32, width of retire_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  IR[31:26]; valid from ID onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  PC load strobe.
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address, 11 rs.
- ir_write  out  1  IR load strobe.
- i_or_d  out  1  0 = PC address, 1 = ALUOut address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_byte  out  2  00 word, 10 half, 11 byte.
- mem_sign  out  1  sign-extend load data.
- reg_write  out  1  register file write strobe.
- reg_dst  out  2  00 rd, 01 rt, 10 $31.
- to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  2  00 PC, 01 A(rs), 10 zero-extended shamt.
- alu_src_b  out  2  00 B(rt), 01 constant 4, 10 ext imm16, 11 ext imm16<<2.
- extend_sign  out  1  1 = sign-extend imm16, 0 = zero-extend.
- alu_op  out  ALU_OP_W  operation code.
- illegal_instr  out  1  one-cycle pulse in ID on an undecodable instruction.
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4.
- retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset:
  - Synchronous, active-high; rst sampled at clk edge sets state=IF and retire_cnt=0.
  - While rst is high, all strobes are forced 0: pc_write, ir_write, mem_read, mem_write, reg_write, illegal_instr.
  - All selects are 0 during reset.
  - Reset mid-instruction aborts it without retiring.
- Outputs are Moore: combinational from state plus opcode/funct; no output latency beyond state.
- alu_op encoding:
  - add 0000, sub 0001, and 0010, or 0011, xor 0100.
  - nor 0101, slt 0110, sltu 0111, addu 1000, subu 1001.
  - sll/sllv 1010, lui 1011, srl/srlv 1100, sra/srav 1101.
- IF:
  - mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=add, pc_src=00.
  - ir_write and pc_write are high only in the cycle mem_ready=1; advance to ID on that cycle, else hold.
- ID:
  - alu_src_a=00, alu_src_b=11, extend_sign=1, alu_op=add (branch target into ALUOut).
  - Undecodable opcode/funct: illegal_instr=1, go to IF, no retire.
  - Otherwise go to EX.
- EX:
  - R-type: alu_src_a=10 for sll/srl/sra, else 01; alu_src_b=00; alu_op from funct; go to WB.
  - I-ALU (addi, andi, ori, slti, lui): alu_src_a=01, alu_src_b=10; extend_sign=0 for andi/ori/lui, else 1; go to WB.
  - Load/store: alu_src_a=01, alu_src_b=10, extend_sign=1, alu_op=add; go to MEM.
  - beq/bne: alu_src_a=01, alu_src_b=00, alu_op=sub, pc_src=01.
    - pc_write = (beq & zero) | (bne & ~zero).
    - Retire, go to IF.
  - j: pc_src=10, pc_write=1; retire, go to IF.
  - jal: as j, plus reg_write=1, reg_dst=10, to_reg=10; retire, go to IF.
  - jr: pc_src=11, pc_write=1; retire, go to IF.
  - jalr: as jr, plus reg_write=1, reg_dst=00, to_reg=10; retire, go to IF.
- MEM:
  - i_or_d=1; mem_byte/mem_sign per lw/lh/lhu/lb/lbu/sw/sh/sb.
  - Loads: mem_read=1; go to WB when mem_ready.
  - Stores: mem_write=1; go to IF and retire when mem_ready.
  - Requests held steady while waiting.
- WB:
  - reg_write=1, 1 cycle, retire, go to IF.
  - R-type: reg_dst=00, to_reg=00.
  - I-ALU: reg_dst=01, to_reg=00.
  - Load: reg_dst=01, to_reg=01.
- Zero-wait latencies:
  - branch/jump: 3 cycles.
  - R-type, I-ALU, store: 4 cycles.
  - load: 5 cycles.
- retire_cnt increments by 1 in the cycle leaving the final state; wraps 2^CNT_W-1 → 0.
- Illegal instructions and reset-aborted instructions do not count.

Test Plan:
- rst high 2 cycles with mem_ready=1 -> state=0, all strobes 0, retire_cnt=0; first IF cycle after release: mem_read=1, ir_write=1, pc_write=1.
- add (opcode 000000, funct 100000), MEM_HS=1, mem_ready=1 -> states 0,1,2,4,0; alu_op=0000 in EX; reg_write=1 in WB only; retire_cnt=1.
- lw, mem_ready low 2 cycles in both IF and MEM -> 9 total cycles; mem_read held throughout; mem_byte=00, mem_sign=1 in MEM; to_reg=01 in WB.
- beq with zero=1, then bne with zero=1 -> pc_write=1/pc_src=01 for beq; pc_write=0 for bne; each 3 cycles; retire_cnt +2.
- jal -> EX: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, to_reg=10; opcode 111111 -> illegal_instr pulse in ID, back to IF, retire_cnt unchanged.
- rst asserted while sw waits in MEM -> next cycle state=0, mem_write=0, retire_cnt=0. With CNT_W=4 at 15: one retire -> 0.

Source files
------------

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM (IF/ID/EX/MEM/WB) driving all
// datapath selects and write strobes, with an optional memory wait handshake
// and a retired-instruction counter.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_opcode, i_funct       instruction register fields (valid from ID on)
//   i_zero                  ALU zero flag (branch resolution in EX)
//   i_mem_ready             memory access completes this cycle
//   o_pc_write .. o_alu_op  datapath strobes and mux selects (combinational)
//   o_illegal_instr         one-cycle pulse in ID for an undecodable instruction
//   o_state                 current FSM state (IF=0 .. WB=4)
//   o_retire_cnt            retired-instruction count, wraps
module multi_cycle_control_fsm #(
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned MEM_HS   = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [5:0]          i_opcode,
  input  logic [5:0]          i_funct,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_pc_write,
  output logic [1:0]          o_pc_src,
  output logic                o_ir_write,
  output logic                o_i_or_d,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic [1:0]          o_mem_byte,
  output logic                o_mem_sign,
  output logic                o_reg_write,
  output logic [1:0]          o_reg_dst,
  output logic [1:0]          o_to_reg,
  output logic [1:0]          o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic                o_extend_sign,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_illegal_instr,
  output logic [2:0]          o_state,
  output logic [CNT_W-1:0]    o_retire_cnt
);

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_ILL, CL_RALU, CL_IALU, CL_LOAD, CL_STORE,
    CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_JALR
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LB   = 6'h20, OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23, OP_LBU  = 6'h24, OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08, F_JALR = 6'h09, F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3, ALU_XOR  = 4'h4, ALU_NOR = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6, ALU_SLTU = 4'h7, ALU_ADDU = 4'h8;
  localparam logic [3:0] ALU_SUBU = 4'h9, ALU_SLL  = 4'hA, ALU_LUI = 4'hB;
  localparam logic [3:0] ALU_SRL  = 4'hC, ALU_SRA  = 4'hD;

  state_t     r_state;
  state_t     w_next;
  cls_t       w_cls;
  logic [3:0] w_alu_code;
  logic [3:0] w_alu_sel;
  logic       w_shamt_src;
  logic       w_ext_zero;
  logic [1:0] w_mem_byte;
  logic       w_mem_sign;
  logic       w_ready;
  logic       w_retire;
  logic [CNT_W-1:0] r_retire_cnt;

  // Without the handshake, memory is assumed to complete every cycle.
  assign w_ready = (MEM_HS != 0) ? i_mem_ready : 1'b1;

  // Instruction decode into a class plus per-class attributes.
  always_comb begin
    w_cls       = CL_ILL;
    w_alu_code  = ALU_ADD;
    w_shamt_src = 1'b0;
    w_ext_zero  = 1'b0;
    w_mem_byte  = 2'b00;
    w_mem_sign  = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        w_cls = CL_RALU;
        case (i_funct)
          F_SLL:   begin w_alu_code = ALU_SLL; w_shamt_src = 1'b1; end
          F_SRL:   begin w_alu_code = ALU_SRL; w_shamt_src = 1'b1; end
          F_SRA:   begin w_alu_code = ALU_SRA; w_shamt_src = 1'b1; end
          F_SLLV:  w_alu_code = ALU_SLL;
          F_SRLV:  w_alu_code = ALU_SRL;
          F_SRAV:  w_alu_code = ALU_SRA;
          F_JR:    w_cls = CL_JR;
          F_JALR:  w_cls = CL_JALR;
          F_ADD:   w_alu_code = ALU_ADD;
          F_ADDU:  w_alu_code = ALU_ADDU;
          F_SUB:   w_alu_code = ALU_SUB;
          F_SUBU:  w_alu_code = ALU_SUBU;
          F_AND:   w_alu_code = ALU_AND;
          F_OR:    w_alu_code = ALU_OR;
          F_XOR:   w_alu_code = ALU_XOR;
          F_NOR:   w_alu_code = ALU_NOR;
          F_SLT:   w_alu_code = ALU_SLT;
          F_SLTU:  w_alu_code = ALU_SLTU;
          default: w_cls = CL_ILL;
        endcase
      end
      OP_J:    w_cls = CL_J;
      OP_JAL:  w_cls = CL_JAL;
      OP_BEQ:  begin w_cls = CL_BEQ; w_alu_code = ALU_SUB; end
      OP_BNE:  begin w_cls = CL_BNE; w_alu_code = ALU_SUB; end
      OP_ADDI: w_cls = CL_IALU;
      OP_SLTI: begin w_cls = CL_IALU; w_alu_code = ALU_SLT; end
      OP_ANDI: begin w_cls = CL_IALU; w_alu_code = ALU_AND; w_ext_zero = 1'b1; end
      OP_ORI:  begin w_cls = CL_IALU; w_alu_code = ALU_OR;  w_ext_zero = 1'b1; end
      OP_LUI:  begin w_cls = CL_IALU; w_alu_code = ALU_LUI; w_ext_zero = 1'b1; end
      OP_LW:   begin w_cls = CL_LOAD;  w_mem_byte = 2'b00; w_mem_sign = 1'b1; end
      OP_LH:   begin w_cls = CL_LOAD;  w_mem_byte = 2'b10; w_mem_sign = 1'b1; end
      OP_LHU:  begin w_cls = CL_LOAD;  w_mem_byte = 2'b10; end
      OP_LB:   begin w_cls = CL_LOAD;  w_mem_byte = 2'b11; w_mem_sign = 1'b1; end
      OP_LBU:  begin w_cls = CL_LOAD;  w_mem_byte = 2'b11; end
      OP_SW:   begin w_cls = CL_STORE; w_mem_byte = 2'b00; end
      OP_SH:   begin w_cls = CL_STORE; w_mem_byte = 2'b10; end
      OP_SB:   begin w_cls = CL_STORE; w_mem_byte = 2'b11; end
      default: w_cls = CL_ILL;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IF;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IF:  if (w_ready) w_next = ST_ID;
      ST_ID:  w_next = (w_cls == CL_ILL) ? ST_IF : ST_EX;
      ST_EX: begin
        case (w_cls)
          CL_RALU, CL_IALU:  w_next = ST_WB;
          CL_LOAD, CL_STORE: w_next = ST_MEM;
          default:           w_next = ST_IF;
        endcase
      end
      ST_MEM: if (w_ready) w_next = (w_cls == CL_LOAD) ? ST_WB : ST_IF;
      ST_WB:  w_next = ST_IF;
      default: w_next = ST_IF;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      ST_EX:  w_retire = (w_cls == CL_BEQ) || (w_cls == CL_BNE) || (w_cls == CL_J) ||
                         (w_cls == CL_JAL) || (w_cls == CL_JR)  || (w_cls == CL_JALR);
      ST_MEM: w_retire = (w_cls == CL_STORE) && w_ready;
      ST_WB:  w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  // Retired-instruction counter; reset drops any in-flight instruction.
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_retire_cnt <= '0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
  end

  // Moore outputs; reset forces every strobe and select to zero.
  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_src        = 2'b00;
    o_ir_write      = 1'b0;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_byte      = 2'b00;
    o_mem_sign      = 1'b0;
    o_reg_write     = 1'b0;
    o_reg_dst       = 2'b00;
    o_to_reg        = 2'b00;
    o_alu_src_a     = 2'b00;
    o_alu_src_b     = 2'b00;
    o_extend_sign   = 1'b0;
    w_alu_sel       = ALU_ADD;
    o_illegal_instr = 1'b0;
    if (!i_rst) begin
      case (r_state)
        ST_IF: begin
          o_mem_read  = 1'b1;
          o_alu_src_b = 2'b01;
          o_ir_write  = w_ready;
          o_pc_write  = w_ready;
        end
        ST_ID: begin
          // Speculative branch target into ALUOut.
          o_alu_src_b     = 2'b11;
          o_extend_sign   = 1'b1;
          o_illegal_instr = (w_cls == CL_ILL);
        end
        ST_EX: begin
          case (w_cls)
            CL_RALU: begin
              o_alu_src_a = w_shamt_src ? 2'b10 : 2'b01;
              w_alu_sel   = w_alu_code;
            end
            CL_IALU: begin
              o_alu_src_a   = 2'b01;
              o_alu_src_b   = 2'b10;
              o_extend_sign = ~w_ext_zero;
              w_alu_sel     = w_alu_code;
            end
            CL_LOAD, CL_STORE: begin
              o_alu_src_a   = 2'b01;
              o_alu_src_b   = 2'b10;
              o_extend_sign = 1'b1;
            end
            CL_BEQ, CL_BNE: begin
              o_alu_src_a = 2'b01;
              o_pc_src    = 2'b01;
              w_alu_sel   = ALU_SUB;
              o_pc_write  = (w_cls == CL_BEQ) ? i_zero : ~i_zero;
            end
            CL_J, CL_JAL: begin
              o_pc_src   = 2'b10;
              o_pc_write = 1'b1;
              if (w_cls == CL_JAL) begin
                o_reg_write = 1'b1;
                o_reg_dst   = 2'b10;
                o_to_reg    = 2'b10;
              end
            end
            CL_JR, CL_JALR: begin
              o_pc_src   = 2'b11;
              o_pc_write = 1'b1;
              if (w_cls == CL_JALR) begin
                o_reg_write = 1'b1;
                o_to_reg    = 2'b10;
              end
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          o_i_or_d    = 1'b1;
          o_mem_byte  = w_mem_byte;
          o_mem_sign  = w_mem_sign;
          o_mem_read  = (w_cls == CL_LOAD);
          o_mem_write = (w_cls == CL_STORE);
        end
        ST_WB: begin
          o_reg_write = 1'b1;
          o_reg_dst   = (w_cls == CL_RALU) ? 2'b00 : 2'b01;
          o_to_reg    = (w_cls == CL_LOAD) ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign o_alu_op     = ALU_OP_W'(w_alu_sel);
  assign o_state      = r_state;
  assign o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Bench for multi_cycle_control_fsm: per-cycle expected output vectors are
// pushed when stimulus is driven and popped/compared on the falling edge.
module tb_multi_cycle_control_fsm;

  logic       i_clk;
  logic       i_rst;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_pc_write, o_ir_write, o_i_or_d, o_mem_read, o_mem_write;
  logic       o_mem_sign, o_reg_write, o_extend_sign, o_illegal_instr;
  logic [1:0] o_pc_src, o_mem_byte, o_reg_dst, o_to_reg, o_alu_src_a, o_alu_src_b;
  logic [3:0] o_alu_op;
  logic [2:0] o_state;
  logic [3:0] o_retire_cnt;

  multi_cycle_control_fsm #(.ALU_OP_W(4), .MEM_HS(1), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct(i_funct),
    .i_zero(i_zero), .i_mem_ready(i_mem_ready),
    .o_pc_write(o_pc_write), .o_pc_src(o_pc_src), .o_ir_write(o_ir_write),
    .o_i_or_d(o_i_or_d), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_byte(o_mem_byte), .o_mem_sign(o_mem_sign), .o_reg_write(o_reg_write),
    .o_reg_dst(o_reg_dst), .o_to_reg(o_to_reg), .o_alu_src_a(o_alu_src_a),
    .o_alu_src_b(o_alu_src_b), .o_extend_sign(o_extend_sign), .o_alu_op(o_alu_op),
    .o_illegal_instr(o_illegal_instr), .o_state(o_state), .o_retire_cnt(o_retire_cnt)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw, iod, mr, mw;
    logic [1:0] mb;
    logic       ms, rw;
    logic [1:0] rd, tr, sa, sb;
    logic       es;
    logic [3:0] ao;
    logic       ill;
    logic [3:0] cnt;
  } vec_t;

  vec_t  act;
  vec_t  exp_q[$];
  string tag_q[$];
  int    n_total = 0;
  int    n_bad   = 0;
  logic [3:0] ecnt = 4'd0;

  assign act = {o_state, o_pc_write, o_pc_src, o_ir_write, o_i_or_d, o_mem_read,
                o_mem_write, o_mem_byte, o_mem_sign, o_reg_write, o_reg_dst, o_to_reg,
                o_alu_src_a, o_alu_src_b, o_extend_sign, o_alu_op, o_illegal_instr,
                o_retire_cnt};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (exp_q.size() != 0) begin
      vec_t  ev;
      string tg;
      ev = exp_q.pop_front();
      tg = tag_q.pop_front();
      check_val(tg, act, ev);
    end
  end

  // 0 illegal, 1 R-ALU, 2 I-ALU, 3 load, 4 store, 5 beq, 6 bne, 7 j, 8 jal, 9 jr, 10 jalr
  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h08: return 9;
               6'h09: return 10;
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h2A, 6'h2B: return 1;
               default: return 0;
             endcase
      6'h02: return 7;
      6'h03: return 8;
      6'h04: return 5;
      6'h05: return 6;
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return 2;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return 3;
      6'h28, 6'h29, 6'h2B: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] r_aluop(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'h0;  6'h22: return 4'h1;  6'h24: return 4'h2;
      6'h25: return 4'h3;  6'h26: return 4'h4;  6'h27: return 4'h5;
      6'h2A: return 4'h6;  6'h2B: return 4'h7;  6'h21: return 4'h8;
      6'h23: return 4'h9;
      6'h00, 6'h04: return 4'hA;
      6'h02, 6'h06: return 4'hC;
      6'h03, 6'h07: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] i_aluop(input logic [5:0] op);
    case (op)
      6'h0A: return 4'h6;
      6'h0C: return 4'h2;
      6'h0D: return 4'h3;
      6'h0F: return 4'hB;
      default: return 4'h0;
    endcase
  endfunction

  function automatic vec_t if_vec(input logic rdy, input logic [3:0] c);
    vec_t e = '0;
    e.mr = 1'b1; e.sb = 2'b01; e.pcw = rdy; e.irw = rdy; e.cnt = c;
    return e;
  endfunction

  task automatic drive(input logic rst, input logic rdy, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic push,
                       input vec_t e, input string tag);
    @(posedge i_clk);
    #1;
    i_rst = rst; i_mem_ready = rdy; i_opcode = op; i_funct = fn; i_zero = z;
    if (push) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wi, input int wm, input bit abort);
    vec_t e;
    int   c;
    c = cls_of(op, fn);
    for (int k = 0; k < wi; k++) drive(0, 0, op, fn, z, 1, if_vec(0, ecnt), {nm, ".IFw"});
    drive(0, 1, op, fn, z, 1, if_vec(1, ecnt), {nm, ".IF"});
    e = '0; e.cnt = ecnt; e.st = 3'd1; e.sb = 2'b11; e.es = 1'b1; e.ill = (c == 0);
    drive(0, 1, op, fn, z, 1, e, {nm, ".ID"});
    if (c == 0) return;
    e = '0; e.cnt = ecnt; e.st = 3'd2;
    case (c)
      1: begin
        e.sa = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01;
        e.ao = r_aluop(fn);
      end
      2: begin
        e.sa = 2'b01; e.sb = 2'b10; e.ao = i_aluop(op);
        e.es = !(op == 6'h0C || op == 6'h0D || op == 6'h0F);
      end
      3, 4: begin e.sa = 2'b01; e.sb = 2'b10; e.es = 1'b1; end
      5: begin e.sa = 2'b01; e.ao = 4'h1; e.pcs = 2'b01; e.pcw = z; end
      6: begin e.sa = 2'b01; e.ao = 4'h1; e.pcs = 2'b01; e.pcw = ~z; end
      7: begin e.pcs = 2'b10; e.pcw = 1'b1; end
      8: begin e.pcs = 2'b10; e.pcw = 1'b1; e.rw = 1'b1; e.rd = 2'b10; e.tr = 2'b10; end
      9: begin e.pcs = 2'b11; e.pcw = 1'b1; end
      default: begin e.pcs = 2'b11; e.pcw = 1'b1; e.rw = 1'b1; e.rd = 2'b00; e.tr = 2'b10; end
    endcase
    drive(0, 1, op, fn, z, 1, e, {nm, ".EX"});
    if (c >= 5) begin ecnt = ecnt + 4'd1; return; end
    if (c == 3 || c == 4) begin
      e = '0; e.cnt = ecnt; e.st = 3'd3; e.iod = 1'b1;
      e.mr = (c == 3); e.mw = (c == 4);
      e.mb = (op == 6'h21 || op == 6'h25 || op == 6'h29) ? 2'b10 :
             (op == 6'h20 || op == 6'h24 || op == 6'h28) ? 2'b11 : 2'b00;
      e.ms = (op == 6'h23 || op == 6'h21 || op == 6'h20);
      for (int k = 0; k < wm; k++) drive(0, 0, op, fn, z, 1, e, {nm, ".MEMw"});
      if (abort) begin
        e = '0; e.st = 3'd3; e.cnt = ecnt;
        drive(1, 0, op, fn, z, 1, e, {nm, ".RST"});
        ecnt = 4'd0;
        drive(0, 0, op, fn, z, 1, if_vec(0, ecnt), {nm, ".postRST"});
        return;
      end
      drive(0, 1, op, fn, z, 1, e, {nm, ".MEM"});
      if (c == 4) begin ecnt = ecnt + 4'd1; return; end
    end
    e = '0; e.cnt = ecnt; e.st = 3'd4; e.rw = 1'b1;
    e.rd = (c == 1) ? 2'b00 : 2'b01;
    e.tr = (c == 3) ? 2'b01 : 2'b00;
    drive(0, 1, op, fn, z, 1, e, {nm, ".WB"});
    ecnt = ecnt + 4'd1;
  endtask

  typedef struct { logic [5:0] op; logic [5:0] fn; logic z; } ins_t;
  ins_t mix[$];

  initial begin
    i_rst = 1'b1; i_mem_ready = 1'b1; i_opcode = 6'h00; i_funct = 6'h20; i_zero = 1'b0;
    // Two reset cycles; only the second has a defined state to check.
    drive(1, 1, 6'h00, 6'h20, 0, 0, '0, "rst0");
    drive(1, 1, 6'h00, 6'h20, 0, 1, '0, "rst1");
    run_instr("add", 6'h00, 6'h20, 0, 0, 0, 0);
    run_instr("lw", 6'h23, 6'h00, 0, 2, 2, 0);
    run_instr("beq", 6'h04, 6'h00, 1, 0, 0, 0);
    run_instr("bne", 6'h05, 6'h00, 1, 0, 0, 0);
    run_instr("jal", 6'h03, 6'h00, 0, 0, 0, 0);
    run_instr("ill_op", 6'h3F, 6'h00, 0, 0, 0, 0);
    run_instr("ill_fn", 6'h00, 6'h01, 0, 1, 0, 0);

    mix = '{'{6'h00, 6'h22, 0}, '{6'h00, 6'h00, 0}, '{6'h00, 6'h07, 0}, '{6'h00, 6'h08, 0},
            '{6'h00, 6'h09, 0}, '{6'h08, 6'h00, 0}, '{6'h0C, 6'h00, 0}, '{6'h0D, 6'h00, 0},
            '{6'h0A, 6'h00, 0}, '{6'h0F, 6'h00, 0}, '{6'h20, 6'h00, 0}, '{6'h24, 6'h00, 0},
            '{6'h21, 6'h00, 0}, '{6'h25, 6'h00, 0}, '{6'h29, 6'h00, 0}, '{6'h28, 6'h00, 0},
            '{6'h02, 6'h00, 0}, '{6'h04, 6'h00, 0}, '{6'h05, 6'h00, 0}, '{6'h00, 6'h27, 0},
            '{6'h00, 6'h2B, 0}, '{6'h00, 6'h21, 0}, '{6'h00, 6'h23, 0}, '{6'h00, 6'h26, 0},
            '{6'h00, 6'h02, 0}, '{6'h00, 6'h03, 0}, '{6'h00, 6'h25, 0}, '{6'h00, 6'h2A, 0}};
    foreach (mix[k])
      run_instr($sformatf("mix%0d", k), mix[k].op, mix[k].fn, mix[k].z,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);

    // sw aborted by reset while waiting in MEM.
    run_instr("sw_abort", 6'h2B, 6'h00, 0, 0, 2, 1);
    // Sixteen retires from zero exercise the 15 -> 0 wrap.
    for (int k = 0; k < 16; k++) run_instr($sformatf("wrap%0d", k), 6'h00, 6'h25, 0, 0, 0, 0);
    run_instr("sw", 6'h2B, 6'h00, 0, 0, 0, 0);

    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    check_val("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
